dot_feeder: RTL
===============

Name: dot_feeder

Overview:
- Transmit-side sequencer for `dot_channel_19`.
- Assembles a 288-element activation vector from a narrow input stream and drives it on `d`.
- Steps `cs` through every weight bank. For each bank it raises `load`, waits for the channel's `valid`, captures `q`, and emits the result on a ready/valid output port.
- Sits between the activation buffer and one dot channel; one result per `cs` per vector.

Parameters:
- VEC_LEN, 288: elements per vector. Must be a multiple of LANES.
- LANES, 32: elements accepted per input beat. BEATS = VEC_LEN/LANES = 9.
- NUM_CS, 12: weight banks swept per vector, 1..16. `cs` runs 0..NUM_CS-1.
- TIMEOUT, 64: watchdog limit in cycles. Used only with DOT_FEEDER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  feeder accepts a beat this cycle.
- in_data  in  LANES*`data_len  input beat; element 0 in the LSBs.
- load  out  1  to dot channel `load`.
- cs  out  4  to dot channel `cs`.
- d  out  VEC_LEN*`data_len  to dot channel `d`.
- dot_valid  in  1  from dot channel `valid`.
- dot_q  in  `data_len  from dot channel `q`.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  `data_len  captured dot product.
- out_cs  out  4  bank index of out_data.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky watchdog flag; constant 0 when the feature is off.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-run):
  - state goes to IDLE.
  - load, out_valid, busy, err, cs, out_cs, out_data all 0.
  - d cleared to 0; beat and bank counters cleared.
- FSM states: IDLE, FILL, RUN, EMIT, GAP.
- IDLE:
  - in_ready=1.
  - An accepted beat (in_valid & in_ready) is written to beat 0 and moves the FSM to FILL with beat_cnt=1.
- FILL:
  - in_ready=1.
  - Beat k is written to d[k*LANES*`data_len +: LANES*`data_len].
  - Acceptance of beat BEATS-1 moves the FSM to RUN on the next cycle with cs=0.
  - No handshake in a cycle means nothing is written and beat_cnt is held.
- RUN:
  - in_ready=0; load=1; d and cs held stable.
  - First RUN cycle is the cycle after the last beat is accepted (latency 1).
  - On dot_valid=1: dot_q is captured into out_data, cs is copied to out_cs, load drops to 0 next cycle, and the FSM moves to EMIT.
  - dot_valid while load=0 is ignored.
- EMIT:
  - out_valid=1; load=0.
  - out_data and out_cs are held until out_valid & out_ready.
  - out_ready may be held low indefinitely.
  - On handshake:
    - If cs==NUM_CS-1, go to IDLE (cs returns to 0).
    - Otherwise cs increments and the FSM goes to GAP.
- GAP:
  - Exactly 1 cycle with load=0.
  - Guarantees a 0→1 edge on load so the dot channel re-initialises.
  - Then go to RUN.
- Load timing:
  - load is low for at least 2 cycles between consecutive banks (EMIT ≥1 + GAP 1).
  - From RUN entry to dot_valid, the nominal interval is 13 cycles. The feeder does not count it; it waits for dot_valid.
- Input back-pressure:
  - The next vector cannot enter until IDLE.
  - An in_valid beat arriving during RUN/EMIT/GAP waits (in_ready=0).
- Simultaneous events:
  - out handshake and cs==NUM_CS-1 in the same cycle: next state is IDLE; in_ready=1 from the following cycle.
  - rst has priority over all events.
- All counters are unsigned.
  - beat_cnt is wide enough for BEATS-1.
  - cs width is 4 bits; it never wraps, because NUM_CS ≤ 16 ends the sweep.

Optional Feature:
- Macro: DOT_FEEDER_TIMEOUT_EN.
- Defined:
  - A watchdog counts RUN cycles per bank and resets on RUN entry.
  - If it reaches TIMEOUT without dot_valid:
    - err is set (sticky until rst) and load drops.
    - out_data=0 and out_cs=cs are presented.
    - The FSM goes to EMIT, and the sweep continues normally.
- Undefined:
  - No counter logic; err tied to 0.
  - RUN waits forever for dot_valid.

Test Plan:
- Fill and first bank: 9 beats with element i = i mod 256 (`data_len=8), NUM_CS=1, channel model returns dot_valid 13 cycles after load rises with q=8'h5A. Required:
  - d holds the ramp.
  - load rises the cycle after beat 8 is accepted.
  - out_data=8'h5A, out_cs=0.
  - FSM returns to IDLE after out_ready.
- Full sweep: NUM_CS=12, model returns q=cs+1. Required:
  - 12 results in order, out_cs 0..11, out_data 1..12.
  - load low ≥2 cycles between banks.
  - 12 rising edges of load in total.
- Output stall: out_ready held 0 for 20 cycles at bank 3. Required:
  - out_valid stays 1 with out_data/out_cs stable.
  - load stays 0.
  - cs does not advance.
- Input gaps and back-pressure:
  - in_valid toggled 1/0 during FILL: every beat lands at the correct slice.
  - in_valid=1 during RUN: in_ready=0 and d is unchanged.
- Mid-run reset: rst=1 for 1 cycle while load=1 at bank 5. Required:
  - Next cycle load=0, out_valid=0, cs=0, d=0, busy=0.
  - A new vector is then processed correctly from bank 0.
- Timeout (with DOT_FEEDER_TIMEOUT_EN, TIMEOUT=64): model never asserts dot_valid. Required:
  - After 64 RUN cycles err=1, out_data=0, out_cs=0.
  - The sweep continues to bank 1.
  - err remains 1 until rst.

Source files
------------

// File: rtl/dot_feeder_if.sv
// Bus bundle for dot_feeder: activation input stream, dot channel drive and result output.
// Element width comes from the `DATA_LEN macro (8 if not defined elsewhere).
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

interface dot_feeder_if #(
    parameter int VEC_LEN = 288,
    parameter int LANES   = 32
);
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*`DATA_LEN-1:0]   in_data;

    logic                         load;
    logic [3:0]                   cs;
    logic [VEC_LEN*`DATA_LEN-1:0] d;
    logic                         dot_valid;
    logic [`DATA_LEN-1:0]         dot_q;

    logic                         out_valid;
    logic                         out_ready;
    logic [`DATA_LEN-1:0]         out_data;
    logic [3:0]                   out_cs;

    modport master (
        input  in_valid, in_data, dot_valid, dot_q, out_ready,
        output in_ready, load, cs, d, out_valid, out_data, out_cs
    );

    modport slave (
        output in_valid, in_data, dot_valid, dot_q, out_ready,
        input  in_ready, load, cs, d, out_valid, out_data, out_cs
    );
endinterface

// File: rtl/dot_feeder.sv
// Transmit-side sequencer for dot_channel_19: assembles a VEC_LEN vector, then sweeps cs over NUM_CS banks.
// Optional RUN watchdog enabled by defining DOT_FEEDER_TIMEOUT_EN.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module dot_feeder #(
    parameter int VEC_LEN = 288,
    parameter int LANES   = 32,
    parameter int NUM_CS  = 12,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    dot_feeder_if.master bus,
    output logic         busy,
    output logic         err
);
    // state | meaning
    // IDLE  | waiting for beat 0 of a new vector
    // FILL  | collecting beats 1..BEATS-1 into d
    // RUN   | load high, waiting for the channel result of bank cs
    // EMIT  | result presented on out_*, waiting for out_ready
    // GAP   | one load-low cycle so the channel sees a fresh rising edge

    localparam int DL    = `DATA_LEN;
    localparam int W     = LANES * DL;
    localparam int BEATS = VEC_LEN / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [3:0]    LAST_CS   = 4'(NUM_CS - 1);

    generate
        if ((VEC_LEN % LANES) != 0 || NUM_CS < 1 || NUM_CS > 16 || TIMEOUT < 1) begin : g_bad_cfg
            $error("dot_feeder: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        RUN  = 3'd2,
        EMIT = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [BW-1:0]         beat_cnt;
    logic [VEC_LEN*DL-1:0] d_q;
    logic [3:0]            cs_q;
    logic [DL-1:0]         out_data_q;
    logic [3:0]            out_cs_q;

    logic in_open;
    logic beat_fire;
    logic last_beat;
    logic dot_hit;
    logic out_fire;
    logic time_out;

    assign in_open   = (state == IDLE) || (state == FILL);
    assign beat_fire = bus.in_valid && in_open;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign dot_hit   = (state == RUN) && bus.dot_valid;
    assign out_fire  = (state == EMIT) && bus.out_ready;

    assign bus.in_ready  = in_open;
    assign bus.load      = (state == RUN);
    assign bus.out_valid = (state == EMIT);
    assign bus.cs        = cs_q;
    assign bus.d         = d_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_cs    = out_cs_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (beat_fire) begin
                    state_nxt = last_beat ? RUN : FILL;
                end
            end
            FILL: begin
                if (beat_fire && last_beat) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (dot_hit || time_out) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    state_nxt = (cs_q == LAST_CS) ? IDLE : GAP;
                end
            end
            GAP: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            d_q        <= '0;
            cs_q       <= '0;
            out_data_q <= '0;
            out_cs_q   <= '0;
        end else begin
            if (beat_fire) begin
                d_q[int'(beat_cnt)*W +: W] <= bus.in_data;
                beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
            end
            // A real result wins over a watchdog expiry in the same cycle.
            if (dot_hit) begin
                out_data_q <= bus.dot_q;
                out_cs_q   <= cs_q;
            end else if (time_out) begin
                out_data_q <= '0;
                out_cs_q   <= cs_q;
            end
            if (out_fire) begin
                cs_q <= (cs_q == LAST_CS) ? 4'd0 : cs_q + 4'd1;
            end
        end
    end

`ifdef DOT_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt;
    logic          err_q;

    // Down-counter reloads outside RUN, so every bank gets a full TIMEOUT window.
    assign time_out = (state == RUN) && !bus.dot_valid && (wd_cnt == '0);
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= TW'(TIMEOUT - 1);
            err_q  <= 1'b0;
        end else begin
            if (state != RUN) begin
                wd_cnt <= TW'(TIMEOUT - 1);
            end else if (wd_cnt != '0) begin
                wd_cnt <= wd_cnt - TW'(1);
            end
            if (time_out) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign time_out = 1'b0;
    assign err      = 1'b0;
`endif

endmodule
